llc_mem_bridge: RTL

// - Sits directly downstream of the LLC core, between its llc_mem_req/llc_mem_rsp channels and the memory bus.
// - Converts each line-granular request into a word-serial burst: one address phase, then WORDS_PER_LINE data beats.
// - For reads, assembles the returned beats into a full line and returns it on llc_mem_rsp.
// - One transaction in flight; no reordering.

---
 rtl/llc_mem_bridge_pkg.sv | 28 ++
 rtl/llc_line_serdes.sv | 54 +++++
 rtl/llc_mem_bridge.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/llc_mem_bridge_pkg.sv
// Shared cache package: line/word types, bridge FSM state and geometry constants.
// Used by the LLC core and by the LLC-to-memory bridge.
package llc_mem_bridge_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_BITS      = 64;
    localparam int ADDR_BITS      = 32;
    localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS;
    localparam int OFFSET_BITS    = $clog2(LINE_BITS / 8);
    localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int CNT_BITS       = $clog2(WORDS_PER_LINE);

    typedef logic [WORD_BITS-1:0]      word_t;
    typedef word_t [WORDS_PER_LINE-1:0] line_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [CNT_BITS-1:0]       cnt_t;

    localparam cnt_t LAST_CNT = cnt_t'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_RSP
    } llc_mem_bridge_state_t;

endpackage

// File: rtl/llc_line_serdes.sv
// Line register with beat counter: parallel load, per-beat word select and
// indexed word write. Ports: load_i/line_i (capture line, cnt=0), wr_i/word_i
// (write word[cnt]), adv_i (cnt++), line_o, word_o (word[cnt]), last_o.
module llc_line_serdes
    import llc_mem_bridge_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  line_t line_i,
    input  logic  wr_i,
    input  word_t word_i,
    input  logic  adv_i,
    output line_t line_o,
    output word_t word_o,
    output logic  last_o
);

    line_t line_q, line_d;
    cnt_t  cnt_q, cnt_d;

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            line_d = line_i;
            cnt_d  = '0;
        end else begin
            if (wr_i) begin
                line_d[cnt_q] = word_i;
            end
            // Counter is exactly log2(words) wide, so it wraps to 0
            // naturally after the final beat.
            if (adv_i) begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = line_q;
    assign word_o = line_q[cnt_q];
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/llc_mem_bridge.sv
// LLC-to-memory bridge: turns line requests into an address phase plus a
// word-serial burst; read beats are assembled and returned as a fill line.
// Ports: llc_mem_req_* (line request), llc_mem_rsp_* (fill line), mem_req_*
// (address phase), mem_wdata_* (write beats), mem_rdata_* (read beats), proto_err.
module llc_mem_bridge
    import llc_mem_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             llc_mem_req_valid,
    output logic             llc_mem_req_ready,
    input  logic             llc_mem_req_hwrite,
    input  logic             llc_mem_req_hprot,
    input  line_addr_t       llc_mem_req_addr,
    input  line_t            llc_mem_req_line,
    output logic             llc_mem_rsp_valid,
    input  logic             llc_mem_rsp_ready,
    output line_t            llc_mem_rsp_line,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_write,
    output logic             mem_req_hprot,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [7:0]       mem_req_len,
    output logic             mem_wdata_valid,
    input  logic             mem_wdata_ready,
    output word_t            mem_wdata,
    output logic             mem_wdata_last,
    input  logic             mem_rdata_valid,
    output logic             mem_rdata_ready,
    input  word_t            mem_rdata,
    input  logic             mem_rdata_last,
    output logic             proto_err
);

    llc_mem_bridge_state_t state_q, state_d;
    logic       hwrite_q, hwrite_d;
    logic       hprot_q, hprot_d;
    line_addr_t addr_q, addr_d;
    logic       proto_err_q, proto_err_d;

    logic  sd_load, sd_wr, sd_adv, sd_last;
    word_t sd_word;

    llc_line_serdes u_serdes (
        .clk    (clk),
        .rst    (rst),
        .load_i (sd_load),
        .line_i (llc_mem_req_line),
        .wr_i   (sd_wr),
        .word_i (mem_rdata),
        .adv_i  (sd_adv),
        .line_o (llc_mem_rsp_line),
        .word_o (sd_word),
        .last_o (sd_last)
    );

    // Valids/readies derive from state only, never from the partner ready.
    always_comb begin
        state_d           = state_q;
        hwrite_d          = hwrite_q;
        hprot_d           = hprot_q;
        addr_d            = addr_q;
        proto_err_d       = proto_err_q;
        sd_load           = 1'b0;
        sd_wr             = 1'b0;
        sd_adv            = 1'b0;
        llc_mem_req_ready = 1'b0;
        llc_mem_rsp_valid = 1'b0;
        mem_req_valid     = 1'b0;
        mem_wdata_valid   = 1'b0;
        mem_wdata_last    = 1'b0;
        mem_rdata_ready   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                llc_mem_req_ready = 1'b1;
                if (llc_mem_req_valid) begin
                    hwrite_d = llc_mem_req_hwrite;
                    hprot_d  = llc_mem_req_hprot;
                    addr_d   = llc_mem_req_addr;
                    sd_load  = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = hwrite_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                mem_wdata_valid = 1'b1;
                mem_wdata_last  = sd_last;
                if (mem_wdata_ready) begin
                    sd_adv = 1'b1;
                    if (sd_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RDATA: begin
                mem_rdata_ready = 1'b1;
                if (mem_rdata_valid) begin
                    sd_wr  = 1'b1;
                    sd_adv = 1'b1;
                    // Our own count ends the burst; a disagreeing
                    // last flag from memory is only flagged.
                    if (mem_rdata_last != sd_last) begin
                        proto_err_d = 1'b1;
                    end
                    if (sd_last) begin
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                llc_mem_rsp_valid = 1'b1;
                if (llc_mem_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hwrite_q    <= 1'b0;
            hprot_q     <= 1'b0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hwrite_q    <= hwrite_d;
            hprot_q     <= hprot_d;
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_req_write = hwrite_q;
    assign mem_req_hprot = hprot_q;
    assign mem_req_addr  = {addr_q, {OFFSET_BITS{1'b0}}};
    assign mem_req_len   = 8'(WORDS_PER_LINE - 1);
    assign mem_wdata     = sd_word;
    assign proto_err     = proto_err_q;

endmodule
